// File: rtl/serie_paralelo.sv
// rtl/serie_paralelo.sv - serial-to-parallel receiver with comma alignment and lock detection
module serie_paralelo #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         LOCK_COUNT = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       data_inS,
    output logic [7:0] data_outP,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

    state_t     state;
    logic [7:0] sr;
    logic [2:0] bit_cnt;
    logic [3:0] bc_cnt;
    logic [7:0] win;
    logic       boundary;

    // The byte completed on this edge includes the bit being sampled now.
    assign win      = {sr[6:0], data_inS};
    assign boundary = (bit_cnt == 3'd7);

    // Alignment search, comma counting and byte delivery on the bit clock.
    always_ff @(posedge clk_8f) begin
        if (!reset) begin
            state       <= SEARCH;
            sr          <= 8'd0;
            bit_cnt     <= 3'd0;
            bc_cnt      <= 4'd0;
            data_outP   <= 8'd0;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            sr          <= win;
            byte_strobe <= 1'b0;
            case (state)
                SEARCH: begin
                    valid_out <= 1'b0;
                    // Any bit offset may start alignment; the comma ending
                    // here defines where the following bytes end.
                    if (win == COMMA) begin
                        bit_cnt <= 3'd0;
                        bc_cnt  <= 4'd1;
                        state   <= LOCKING;
                    end
                end
                LOCKING: begin
                    valid_out <= 1'b0;
                    bit_cnt   <= bit_cnt + 3'd1;
                    if (boundary) begin
                        if (win == COMMA) begin
                            bc_cnt <= bc_cnt + 4'd1;
                            if (bc_cnt + 4'd1 == LOCK_TARGET) begin
                                state  <= ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            // Broken comma run: drop alignment and hunt again
                            // starting with the next bit.
                            bc_cnt <= 4'd0;
                            state  <= SEARCH;
                        end
                    end
                end
                ACTIVE: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        byte_strobe <= 1'b1;
                        if (win != COMMA) begin
                            data_outP <= win;
                            valid_out <= 1'b1;
                        end else begin
                            valid_out <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= SEARCH;
                end
            endcase
        end
    end

endmodule
